stencil_stream_source: RTL
==========================

// Module: stencil_stream_source
// PURPOSE
//   Synthesizable producer for an accelerator's pulled input port (*_read_en / *_read[0]).
//   A host preloads a frame into an internal memory, pulses start, and the block serves words
//   in show-ahead order: read_data always holds the word at the head of the stream, and each
//   cycle with read_en high consumes it. Replaces the behavioural input driver in power/flow
//   benches so that gaussian-class apps can be run at gate level with real stimulus.
// PARAMETERS
//   WIDTH    16   data word width (matches stencil port width)
//   DEPTH    64   frame memory depth in words (power of 2, >=2)
//   REPEATS  1    frame replays served per start (>=1)
// PORTS
//   clk          in   1               clock, rising edge
//   rst_n        in   1               asynchronous reset, active low
//   flush        in   1               synchronous clear to IDLE; memory contents kept
//   load_valid   in   1               host write strobe
//   load_data    in   WIDTH           host write data
//   load_ready   out  1               state==IDLE && loaded<DEPTH
//   start        in   1               begin streaming the loaded frame
//   read_en      in   1               accelerator consumes read_data this cycle
//   read_data    out  WIDTH           head-of-stream word (registered)
//   read_valid   out  1               state==STREAM
//   done         out  1               one-cycle pulse after last word of last replay consumed
//   underrun     out  1               sticky: read_en seen while read_valid low
//   start_err    out  1               sticky: start seen with zero words loaded
//   words_served out  $clog2(DEPTH*REPEATS)+1  count of consumed words since start
// BEHAVIOUR
//   Reset: state IDLE; read_data=0; loaded, rd_ptr, replay, words_served=0; done, underrun,
//     start_err=0; load_ready=1. Memory is not reset.
//   States: IDLE -> STREAM (start && loaded_eff>0), STREAM -> DONE (last consume),
//     DONE -> IDLE (unconditional, 1 cycle; done=1 only in DONE).
//   IDLE: load_valid && load_ready writes mem[loaded], loaded++. load_valid when loaded==DEPTH
//     is dropped silently. loaded persists across frames; restart replays the same frame.
//   start in IDLE: loaded_eff = loaded + (load_valid && load_ready). If loaded_eff==0 ->
//     start_err<=1, stay IDLE. Else read_data<=mem[0] (bypass load_data when loaded==0),
//     rd_ptr<=0, replay<=0, words_served<=0, STREAM. First consumable cycle is start+1.
//   start outside IDLE is ignored.
//   STREAM, read_en=1: words_served++. If rd_ptr==loaded-1: if replay==REPEATS-1 -> DONE,
//     read_data holds; else replay++, rd_ptr<=0, read_data<=mem[0]. Otherwise rd_ptr++,
//     read_data<=mem[rd_ptr+1]. Sustains one word per cycle, no bubbles, including wrap.
//   STREAM, read_en=0: all state holds; read_data stable.
//   read_en while state!=STREAM: underrun<=1; no pointer or data change.
//   flush (synchronous, highest priority): state IDLE, loaded=0, rd_ptr=0, replay=0,
//     underrun=0, start_err=0, done=0; read_data and words_served hold.
//   rst_n low mid-stream: immediate return to reset values; partial frame abandoned.
//   Counters never wrap: words_served max = DEPTH*REPEATS fits declared width.
// TESTING
//   1. Load 4 words 10,11,12,13; start; read_en held high -> read_data 10,11,12,13 on
//      consecutive cycles, done pulse 1 cycle after 13 consumed, words_served=4.
//   2. REPEATS=2, load 3 words 5,6,7, read_en high -> 5,6,7,5,6,7 no bubble; done once.
//   3. read_en toggled 1,0,0,1 during stream -> read_data held across the 0 cycles; order kept.
//   4. read_en before start and after done -> underrun=1 sticky, read_data unchanged;
//      flush -> underrun=0, load_ready=1, loaded=0.
//   5. start with nothing loaded -> start_err=1, read_valid stays 0; load_valid+start same
//      cycle with loaded=0, load_data=42 -> single-word frame, read_data=42 next cycle.
//   6. Load DEPTH+1 words -> load_ready low after DEPTH, extra word dropped; assert rst_n low
//      mid-stream -> read_valid=0, read_data=0 immediately.

Source files
------------

// File: rtl/stencil_stream_source_if.sv
// stencil_stream_source_if: host load, start and pulled read-stream signals of the frame source
interface stencil_stream_source_if #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 64,
  parameter int REPEATS = 1
);
  localparam int CW = $clog2(DEPTH * REPEATS) + 1;
  logic             flush;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             start;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             done;
  logic             underrun;
  logic             start_err;
  logic [CW-1:0]    words_served;
  modport master (
    output flush, load_valid, load_data, start, read_en,
    input  load_ready, read_data, read_valid, done, underrun, start_err, words_served
  );
  modport slave (
    input  flush, load_valid, load_data, start, read_en,
    output load_ready, read_data, read_valid, done, underrun, start_err, words_served
  );
endinterface

// File: rtl/stencil_stream_source.sv
// stencil_stream_source: preloaded frame memory served as a show-ahead pulled stream
module stencil_stream_source #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 64,
  parameter int REPEATS = 1
) (
  input logic clk,
  input logic rst_n,
  stencil_stream_source_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH * REPEATS) + 1;
  localparam int RW = REPEATS > 1 ? $clog2(REPEATS) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] loaded, loaded_eff;
  logic [AW-1:0] rd_ptr, rd_nxt;
  logic [RW-1:0] replay;
  logic load_fire, start_ok, consume, last_word, last_replay;
  // Handshake decode, next state and state-derived outputs
  always_comb begin
    s.load_ready = state == IDLE && loaded < (AW+1)'(DEPTH);
    load_fire    = s.load_valid && s.load_ready;
    loaded_eff   = loaded + (AW+1)'(load_fire);
    start_ok     = state == IDLE && s.start && loaded_eff != '0;
    consume      = state == STREAM && s.read_en;
    last_word    = {1'b0, rd_ptr} == loaded - (AW+1)'(1);
    last_replay  = replay == RW'(REPEATS - 1);
    rd_nxt       = rd_ptr + AW'(1);
    state_nxt    = state == IDLE   ? (start_ok ? STREAM : IDLE) :
                   state == STREAM ? (consume && last_word && last_replay ? DONE : STREAM) : IDLE;
    s.read_valid = state == STREAM;
    s.done       = state == DONE;
  end
  // State register; flush forces IDLE ahead of any transition
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= s.flush ? IDLE : state_nxt;
  // Frame memory is deliberately unreset; only accepted loads write it
  always_ff @(posedge clk)
    if (load_fire && !s.flush) mem[loaded[AW-1:0]] <= s.load_data;
  // Pointers, counters, sticky flags and the registered head-of-stream word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      loaded         <= '0;
      rd_ptr         <= '0;
      replay         <= '0;
      s.read_data    <= '0;
      s.words_served <= '0;
      s.underrun     <= 1'b0;
      s.start_err    <= 1'b0;
    end else if (s.flush) begin
      loaded      <= '0;
      rd_ptr      <= '0;
      replay      <= '0;
      s.underrun  <= 1'b0;
      s.start_err <= 1'b0;
    end else begin
      if (load_fire) loaded <= loaded + (AW+1)'(1);
      if (s.read_en && state != STREAM) s.underrun <= 1'b1;
      if (state == IDLE && s.start && loaded_eff == '0) s.start_err <= 1'b1;
      if (start_ok) begin
        s.read_data    <= loaded == '0 ? s.load_data : mem[0];
        rd_ptr         <= '0;
        replay         <= '0;
        s.words_served <= '0;
      end else if (consume) begin
        s.words_served <= s.words_served + CW'(1);
        if (!last_word) begin
          rd_ptr      <= rd_nxt;
          s.read_data <= mem[rd_nxt];
        end else if (!last_replay) begin
          replay      <= replay + RW'(1);
          rd_ptr      <= '0;
          s.read_data <= mem[0];
        end
      end
    end
endmodule
